// File: rtl/spu_maexp_gen_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: one-hot states
// and default parameter values.
package spu_maexp_gen_pkg;

  localparam int DEF_EWIDTH  = 64;
  localparam int DEF_CNT_W   = 6;
  localparam int DEF_MEM_LAT = 1;

  localparam int ST_W      = 7;
  localparam int IDX_IDLE  = 0;
  localparam int IDX_RDE   = 1;
  localparam int IDX_RDW   = 2;
  localparam int IDX_SQR   = 3;
  localparam int IDX_ECHK  = 4;
  localparam int IDX_MUL   = 5;
  localparam int IDX_SHFT  = 6;

  // Encodings follow the IDX_* bit positions above.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 7'b000_0001,
    ST_RDE  = 7'b000_0010,
    ST_RDW  = 7'b000_0100,
    ST_SQR  = 7'b000_1000,
    ST_ECHK = 7'b001_0000,
    ST_MUL  = 7'b010_0000,
    ST_SHFT = 7'b100_0000
  } state_t;

endpackage

// File: rtl/spu_maexp_gen_if.sv
// Control/status bundle between the exponent sequencer (master) and the
// surrounding MA control, datapath and mulred blocks (slave).
interface spu_maexp_gen_if
  import spu_maexp_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             spu_mactl_iss_pulse_dly;
  logic             spu_mactl_expop;
  logic             spu_mactl_ct_mode;
  logic [CNT_W-1:0] spu_mactl_es_nwords;
  logic             spu_mactl_kill_op;
  logic             spu_mactl_stxa_force_abort;
  logic             spu_madp_e_msb;
  logic             spu_mared_red_done;

  logic             spu_maexp_memren;
  logic             spu_maexp_e_rd_oprnd_sel;
  logic             spu_maexp_e_data_wen;
  logic             spu_maexp_shift_e;
  logic [CNT_W-1:0] spu_maexp_es_ptr;
  logic             spu_maexp_start_mulred_aequb;
  logic             spu_maexp_start_mulred_anoteqb;
  logic             spu_maexp_mul_discard;
  logic             spu_maexp_busy;
  logic             spu_maexp_done_set;

  modport master (
    input  spu_mactl_iss_pulse_dly, spu_mactl_expop, spu_mactl_ct_mode,
           spu_mactl_es_nwords, spu_mactl_kill_op, spu_mactl_stxa_force_abort,
           spu_madp_e_msb, spu_mared_red_done,
    output spu_maexp_memren, spu_maexp_e_rd_oprnd_sel, spu_maexp_e_data_wen,
           spu_maexp_shift_e, spu_maexp_es_ptr, spu_maexp_start_mulred_aequb,
           spu_maexp_start_mulred_anoteqb, spu_maexp_mul_discard,
           spu_maexp_busy, spu_maexp_done_set
  );

  modport slave (
    output spu_mactl_iss_pulse_dly, spu_mactl_expop, spu_mactl_ct_mode,
           spu_mactl_es_nwords, spu_mactl_kill_op, spu_mactl_stxa_force_abort,
           spu_madp_e_msb, spu_mared_red_done,
    input  spu_maexp_memren, spu_maexp_e_rd_oprnd_sel, spu_maexp_e_data_wen,
           spu_maexp_shift_e, spu_maexp_es_ptr, spu_maexp_start_mulred_aequb,
           spu_maexp_start_mulred_anoteqb, spu_maexp_mul_discard,
           spu_maexp_busy, spu_maexp_done_set
  );

endinterface

// File: rtl/spu_maexp_gen_ctr.sv
// Exponent bit counter and word pointer with last-bit / last-word flags.
module spu_maexp_gen_ctr #(
  parameter int EWIDTH = 64,
  parameter int CNT_W  = 6
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             i_clr_all,
  input  logic             i_clr_bit,
  input  logic             i_inc_bit,
  input  logic             i_inc_word,
  input  logic [CNT_W-1:0] i_nwords,
  output logic [CNT_W-1:0] o_es_ptr,
  output logic             o_last_bit,
  output logic             o_last_word
);

  localparam int BCNT_W = $clog2(EWIDTH);

  logic [BCNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0]  r_es_ptr;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_bit_cnt <= '0;
      r_es_ptr  <= '0;
    end else if (i_clr_all) begin
      r_bit_cnt <= '0;
      r_es_ptr  <= '0;
    end else begin
      if (i_clr_bit)
        r_bit_cnt <= '0;
      else if (i_inc_bit)
        r_bit_cnt <= r_bit_cnt + 1'b1;
      if (i_inc_word)
        r_es_ptr <= r_es_ptr + 1'b1;
    end
  end

  assign o_es_ptr    = r_es_ptr;
  assign o_last_bit  = (r_bit_cnt == BCNT_W'(EWIDTH - 1));
  assign o_last_word = (r_es_ptr == (i_nwords - CNT_W'(1)));

endmodule

// File: rtl/spu_maexp_gen.sv
// Square-and-multiply exponent sequencer: fetches exponent words MSB-first and
// issues square/multiply requests, with an optional constant-time mode.
module spu_maexp_gen
  import spu_maexp_gen_pkg::*;
#(
  parameter int EWIDTH  = DEF_EWIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             se,
  spu_maexp_gen_if.master  bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_nwords;
  logic             r_ct;
  logic [LAT_W-1:0] r_lat;
  logic             r_memren, r_e_wen, r_shift_e;
  logic             r_aequb, r_anoteqb, r_discard, r_done;

  logic             w_start, w_busy, w_in_red, w_abort, w_lat_last, w_finish;
  logic             w_zero_start, w_clr_all, w_clr_bit, w_inc_bit, w_inc_word;
  logic             w_last_bit, w_last_word;
  logic [CNT_W-1:0] w_es_ptr;

  // Scan stitching attaches se downstream; it has no functional effect here.
  logic w_unused_se;
  assign w_unused_se = se;

  assign w_start      = bus.spu_mactl_iss_pulse_dly & bus.spu_mactl_expop;
  assign w_busy       = (r_state != ST_IDLE);
  assign w_in_red     = (r_state == ST_SQR) || (r_state == ST_MUL);
  assign w_abort      = w_busy & (bus.spu_mactl_kill_op |
                        (bus.spu_mactl_stxa_force_abort & bus.spu_mared_red_done & w_in_red));
  assign w_lat_last   = (r_lat == LAT_W'(MEM_LAT));
  assign w_finish     = (r_state == ST_SHFT) & w_last_bit & w_last_word & ~w_abort;
  assign w_zero_start = (r_state == ST_IDLE) & w_start & (bus.spu_mactl_es_nwords == '0);
  assign w_clr_all    = w_abort | ((r_state == ST_IDLE) & w_start) | w_finish;
  assign w_clr_bit    = (r_state == ST_RDW) & w_lat_last;
  assign w_inc_bit    = (r_state == ST_SHFT) & ~w_last_bit & ~w_abort;
  assign w_inc_word   = (r_state == ST_SHFT) & w_last_bit & ~w_last_word & ~w_abort;

  spu_maexp_gen_ctr #(.EWIDTH(EWIDTH), .CNT_W(CNT_W)) u_ctr (
    .rclk        (rclk),
    .arst_l      (arst_l),
    .i_clr_all   (w_clr_all),
    .i_clr_bit   (w_clr_bit),
    .i_inc_bit   (w_inc_bit),
    .i_inc_word  (w_inc_word),
    .i_nwords    (r_nwords),
    .o_es_ptr    (w_es_ptr),
    .o_last_bit  (w_last_bit),
    .o_last_word (w_last_word)
  );

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state   <= ST_IDLE;
      r_nwords  <= '0;
      r_ct      <= 1'b0;
      r_lat     <= '0;
      r_memren  <= 1'b0;
      r_e_wen   <= 1'b0;
      r_shift_e <= 1'b0;
      r_aequb   <= 1'b0;
      r_anoteqb <= 1'b0;
      r_discard <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_memren  <= 1'b0;
      r_e_wen   <= 1'b0;
      r_shift_e <= 1'b0;
      r_aequb   <= 1'b0;
      r_anoteqb <= 1'b0;
      // A new issue clears the sticky flag even if a completion lands the same cycle.
      if (bus.spu_mactl_iss_pulse_dly)
        r_done <= w_zero_start;
      else if (w_finish | (w_abort & bus.spu_mactl_expop))
        r_done <= 1'b1;

      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_discard <= 1'b0;
        r_lat     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_start) begin
            r_nwords <= bus.spu_mactl_es_nwords;
            r_ct     <= bus.spu_mactl_ct_mode;
            if (bus.spu_mactl_es_nwords != '0) begin
              r_state  <= ST_RDE;
              r_memren <= 1'b1;
            end
          end
          ST_RDE: begin
            r_state <= ST_RDW;
            r_lat   <= LAT_W'(1);
            r_e_wen <= (MEM_LAT == 1);
          end
          ST_RDW: if (w_lat_last) begin
            r_state <= ST_SQR;
            r_aequb <= 1'b1;
          end else begin
            r_lat   <= r_lat + 1'b1;
            r_e_wen <= ((r_lat + 1'b1) == LAT_W'(MEM_LAT));
          end
          ST_SQR: if (bus.spu_mared_red_done) r_state <= ST_ECHK;
          ST_ECHK: if (bus.spu_madp_e_msb | r_ct) begin
            r_state   <= ST_MUL;
            r_anoteqb <= 1'b1;
            r_discard <= ~bus.spu_madp_e_msb;
          end else begin
            r_state   <= ST_SHFT;
            r_e_wen   <= 1'b1;
            r_shift_e <= 1'b1;
          end
          ST_MUL: if (bus.spu_mared_red_done) begin
            r_state   <= ST_SHFT;
            r_discard <= 1'b0;
            r_e_wen   <= 1'b1;
            r_shift_e <= 1'b1;
          end
          ST_SHFT: if (!w_last_bit) begin
            r_state <= ST_SQR;
            r_aequb <= 1'b1;
          end else if (w_last_word) begin
            r_state <= ST_IDLE;
          end else begin
            r_state  <= ST_RDE;
            r_memren <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.spu_maexp_memren               = r_memren;
  assign bus.spu_maexp_e_rd_oprnd_sel       = r_memren;
  assign bus.spu_maexp_e_data_wen           = r_e_wen;
  assign bus.spu_maexp_shift_e              = r_shift_e;
  assign bus.spu_maexp_es_ptr               = w_es_ptr;
  assign bus.spu_maexp_start_mulred_aequb   = r_aequb;
  assign bus.spu_maexp_start_mulred_anoteqb = r_anoteqb;
  assign bus.spu_maexp_mul_discard          = r_discard;
  assign bus.spu_maexp_busy                 = w_busy;
  assign bus.spu_maexp_done_set             = r_done;

endmodule

// File: tb/tb_spu_maexp_gen.sv
// Directed bench for spu_maexp_gen with EWIDTH=4: models the E register,
// exponent memory and a fixed-latency mulred responder around the sequencer.
module tb_spu_maexp_gen;

  logic rclk = 1'b0;
  logic arst_l;
  logic se;

  spu_maexp_gen_if #(.CNT_W(6)) bus ();

  spu_maexp_gen #(.EWIDTH(4), .CNT_W(6), .MEM_LAT(1)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .se     (se),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] mem [0:3];
  logic [3:0] e_reg;
  int n_memren, n_aequb, n_anoteqb, n_shift, disc_mask, resp_cnt;
  int ptr_log [0:7];
  bit auto_mul;

  // One cycle: observe outputs at the negedge, update environment models, drive next inputs.
  task automatic tick();
    @(negedge rclk);
    bus.spu_mared_red_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus.spu_mared_red_done = 1'b1;
    end
    if (bus.spu_maexp_memren === 1'b1) begin
      if (n_memren < 8) ptr_log[n_memren] = int'(bus.spu_maexp_es_ptr);
      n_memren++;
    end
    if (bus.spu_maexp_start_mulred_aequb === 1'b1) begin
      n_aequb++;
      resp_cnt = 2;
    end
    if (bus.spu_maexp_start_mulred_anoteqb === 1'b1) begin
      if (bus.spu_maexp_mul_discard === 1'b1) disc_mask |= (1 << n_anoteqb);
      n_anoteqb++;
      if (auto_mul) resp_cnt = 2;
    end
    if (bus.spu_maexp_e_data_wen === 1'b1) begin
      if (bus.spu_maexp_shift_e === 1'b1) begin
        n_shift++;
        e_reg = {e_reg[2:0], 1'b0};
      end else begin
        e_reg = mem[bus.spu_maexp_es_ptr[1:0]];
      end
    end
    bus.spu_madp_e_msb = e_reg[3];
  endtask

  task automatic start_op(input logic [5:0] nwords, input logic ct);
    n_memren = 0; n_aequb = 0; n_anoteqb = 0; n_shift = 0; disc_mask = 0; resp_cnt = 0;
    e_reg = 4'h0;
    bus.spu_madp_e_msb          = 1'b0;
    bus.spu_mactl_es_nwords     = nwords;
    bus.spu_mactl_ct_mode       = ct;
    bus.spu_mactl_expop         = 1'b1;
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.spu_maexp_busy === 1'b1 && k < 400) begin
      tick();
      k++;
    end
    n_cmp++;
    if (bus.spu_maexp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", tag, bus.spu_maexp_busy, k);
    end
  endtask

  task automatic test_reset();
    arst_l = 1'b0;
    repeat (2) @(negedge rclk);
    n_cmp++;
    if ({bus.spu_maexp_memren, bus.spu_maexp_e_data_wen, bus.spu_maexp_start_mulred_aequb,
         bus.spu_maexp_start_mulred_anoteqb, bus.spu_maexp_busy, bus.spu_maexp_done_set,
         bus.spu_maexp_mul_discard} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero/X control outputs, expected all 0");
    end
    n_cmp++;
    if (bus.spu_maexp_es_ptr !== 6'd0) begin
      n_err++;
      $display("FAIL reset_es_ptr: got %0d expected 0", bus.spu_maexp_es_ptr);
    end
    arst_l = 1'b1;
    tick();
    $display("reset: released");
  endtask

  // E=1011, one word: 4 squares, 3 (or 4 in constant-time) multiplies.
  task automatic test_single_word(input logic ct, input string tag);
    int exp_mul;
    mem[0] = 4'b1011;
    exp_mul = ct ? 4 : 3;
    start_op(6'd1, ct);
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_clr: done_set=%b expected 0 after issue", tag, bus.spu_maexp_done_set);
    end
    wait_idle(tag);
    n_cmp++;
    if (n_memren !== 1) begin
      n_err++; $display("FAIL %s_memren: got %0d expected 1", tag, n_memren);
    end
    n_cmp++;
    if (n_aequb !== 4) begin
      n_err++; $display("FAIL %s_aequb: got %0d expected 4", tag, n_aequb);
    end
    n_cmp++;
    if (n_anoteqb !== exp_mul) begin
      n_err++; $display("FAIL %s_anoteqb: got %0d expected %0d", tag, n_anoteqb, exp_mul);
    end
    n_cmp++;
    if (n_shift !== 4) begin
      n_err++; $display("FAIL %s_shift: got %0d expected 4", tag, n_shift);
    end
    n_cmp++;
    if (disc_mask !== (ct ? 2 : 0)) begin
      n_err++; $display("FAIL %s_discard: mask got %0h expected %0h", tag, disc_mask, ct ? 2 : 0);
    end
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b1) begin
      n_err++; $display("FAIL %s_done: done_set=%b expected 1", tag, bus.spu_maexp_done_set);
    end
    $display("%s: E=1011 ct=%0b memren=%0d sqr=%0d mul=%0d shift=%0d", tag, ct, n_memren, n_aequb, n_anoteqb, n_shift);
  endtask

  task automatic test_two_words();
    mem[0] = 4'hF;
    mem[1] = 4'h0;
    start_op(6'd2, 1'b0);
    wait_idle("t3");
    n_cmp++;
    if (n_memren !== 2) begin
      n_err++; $display("FAIL t3_memren: got %0d expected 2", n_memren);
    end
    n_cmp++;
    if (ptr_log[0] !== 0 || ptr_log[1] !== 1) begin
      n_err++; $display("FAIL t3_es_ptr: got %0d,%0d expected 0,1", ptr_log[0], ptr_log[1]);
    end
    n_cmp++;
    if (n_aequb !== 8) begin
      n_err++; $display("FAIL t3_aequb: got %0d expected 8", n_aequb);
    end
    n_cmp++;
    if (n_anoteqb !== 4) begin
      n_err++; $display("FAIL t3_anoteqb: got %0d expected 4", n_anoteqb);
    end
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b1) begin
      n_err++; $display("FAIL t3_done: done_set=%b expected 1", bus.spu_maexp_done_set);
    end
    $display("t3: words F,0 memren=%0d sqr=%0d mul=%0d", n_memren, n_aequb, n_anoteqb);
  endtask

  task automatic test_kill();
    int k = 0;
    auto_mul = 1'b0;
    mem[0] = 4'b1011;
    start_op(6'd1, 1'b0);
    while (n_anoteqb == 0 && k < 200) begin tick(); k++; end
    n_cmp++;
    if (n_anoteqb !== 1) begin
      n_err++; $display("FAIL t4_reach_mul: multiplies=%0d expected 1", n_anoteqb);
    end
    bus.spu_mactl_kill_op   = 1'b1;
    bus.spu_mared_red_done  = 1'b1;
    tick();
    bus.spu_mactl_kill_op   = 1'b0;
    n_cmp++;
    if (bus.spu_maexp_busy !== 1'b0 || bus.spu_maexp_e_data_wen !== 1'b0) begin
      n_err++;
      $display("FAIL t4_idle: busy=%b e_wen=%b expected 0,0", bus.spu_maexp_busy, bus.spu_maexp_e_data_wen);
    end
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b1) begin
      n_err++; $display("FAIL t4_done: done_set=%b expected 1", bus.spu_maexp_done_set);
    end
    repeat (3) tick();
    n_cmp++;
    if (n_shift !== 0 || bus.spu_maexp_busy !== 1'b0) begin
      n_err++; $display("FAIL t4_no_shift: shifts=%0d busy=%b expected 0,0", n_shift, bus.spu_maexp_busy);
    end
    bus.spu_mactl_expop         = 1'b0;
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b0 || bus.spu_maexp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL t4_done_clear: done=%b busy=%b expected 0,0", bus.spu_maexp_done_set, bus.spu_maexp_busy);
    end
    auto_mul = 1'b1;
    $display("t4: kill in MUL -> idle, done set then cleared");
  endtask

  task automatic test_force_abort();
    int k = 0;
    mem[0] = 4'b1011;
    start_op(6'd1, 1'b0);
    while (!(bus.spu_mared_red_done === 1'b1) && k < 200) begin tick(); k++; end
    tick();
    // Now in ECHK: abort with red_done must be ignored here.
    bus.spu_mactl_stxa_force_abort = 1'b1;
    bus.spu_mared_red_done         = 1'b1;
    tick();
    bus.spu_mactl_stxa_force_abort = 1'b0;
    n_cmp++;
    if (bus.spu_maexp_busy !== 1'b1 || n_anoteqb !== 1) begin
      n_err++;
      $display("FAIL t5_echk_ignored: busy=%b mul=%0d expected 1,1", bus.spu_maexp_busy, n_anoteqb);
    end
    k = 0;
    while (n_aequb < 2 && k < 200) begin tick(); k++; end
    resp_cnt = 0;
    bus.spu_mactl_stxa_force_abort = 1'b1;
    bus.spu_mared_red_done         = 1'b1;
    tick();
    bus.spu_mactl_stxa_force_abort = 1'b0;
    n_cmp++;
    if (bus.spu_maexp_busy !== 1'b0 || bus.spu_maexp_done_set !== 1'b1) begin
      n_err++;
      $display("FAIL t5_sqr_abort: busy=%b done=%b expected 0,1", bus.spu_maexp_busy, bus.spu_maexp_done_set);
    end
    n_cmp++;
    if (n_shift !== 1 || n_aequb !== 2) begin
      n_err++; $display("FAIL t5_counts: shifts=%0d sqr=%0d expected 1,2", n_shift, n_aequb);
    end
    bus.spu_mactl_expop         = 1'b0;
    bus.spu_mactl_iss_pulse_dly = 1'b1;
    tick();
    bus.spu_mactl_iss_pulse_dly = 1'b0;
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b0) begin
      n_err++; $display("FAIL t5_pre_clear: done=%b expected 0", bus.spu_maexp_done_set);
    end
    start_op(6'd0, 1'b0);
    n_cmp++;
    if (bus.spu_maexp_done_set !== 1'b1 || bus.spu_maexp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL t5_zero_words: done=%b busy=%b expected 1,0", bus.spu_maexp_done_set, bus.spu_maexp_busy);
    end
    repeat (3) tick();
    n_cmp++;
    if (n_memren !== 0) begin
      n_err++; $display("FAIL t5_zero_memren: got %0d expected 0", n_memren);
    end
    $display("t5: stxa abort ignored in ECHK, honoured in SQR; nwords=0 done");
  endtask

  task automatic test_async_reset();
    mem[0] = 4'b1011;
    start_op(6'd1, 1'b0);
    tick();
    n_cmp++;
    if (bus.spu_maexp_e_data_wen !== 1'b1) begin
      n_err++; $display("FAIL t6_in_rdw: e_wen=%b expected 1", bus.spu_maexp_e_data_wen);
    end
    #1 arst_l = 1'b0;
    #1;
    n_cmp++;
    if ({bus.spu_maexp_busy, bus.spu_maexp_e_data_wen, bus.spu_maexp_memren,
         bus.spu_maexp_done_set} !== 4'b0 || bus.spu_maexp_es_ptr !== 6'd0) begin
      n_err++;
      $display("FAIL t6_async: busy=%b e_wen=%b memren=%b done=%b expected all 0",
               bus.spu_maexp_busy, bus.spu_maexp_e_data_wen, bus.spu_maexp_memren, bus.spu_maexp_done_set);
    end
    @(negedge rclk);
    arst_l = 1'b1;
    resp_cnt = 0;
    bus.spu_mared_red_done = 1'b0;
    $display("t6: async reset mid-RDW, restarting");
    test_single_word(1'b0, "t6");
  endtask

  initial begin
    se = 1'b0;
    auto_mul = 1'b1;
    resp_cnt = 0;
    e_reg = 4'h0;
    for (int i = 0; i < 4; i++) mem[i] = 4'h0;
    for (int i = 0; i < 8; i++) ptr_log[i] = -1;
    bus.spu_mactl_iss_pulse_dly    = 1'b0;
    bus.spu_mactl_expop            = 1'b0;
    bus.spu_mactl_ct_mode          = 1'b0;
    bus.spu_mactl_es_nwords        = 6'd0;
    bus.spu_mactl_kill_op          = 1'b0;
    bus.spu_mactl_stxa_force_abort = 1'b0;
    bus.spu_madp_e_msb             = 1'b0;
    bus.spu_mared_red_done         = 1'b0;

    test_reset();
    test_single_word(1'b0, "t1");
    test_single_word(1'b1, "t2");
    test_two_words();
    test_kill();
    test_force_abort();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
